// File: rtl/axi_r_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_r_pkg
//  Description : Shared types, master tags and helpers for the AXI R router.
//  Revision    : 1.0 - initial release
// ============================================================================
package axi_r_pkg;

    localparam int AXI_ID_BITS   = 4;
    localparam int AXI_IDS_BITS  = 8;
    localparam int AXI_DATA_BITS = 32;

    // Master tags carried in the upper nibble of the extended ID.
    localparam logic [3:0] MTAG_M0 = 4'b0001;
    localparam logic [3:0] MTAG_M1 = 4'b0010;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } r_state_t;

    typedef struct packed {
        logic [AXI_IDS_BITS-1:0]  ids;
        logic [AXI_DATA_BITS-1:0] data;
        logic [1:0]               resp;
        logic                     last;
    } r_beat_t;

    function automatic logic [3:0] tag_of(input logic [AXI_IDS_BITS-1:0] ids);
        tag_of = 4'(ids >> AXI_ID_BITS);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// ============================================================================
//  Module      : rr_picker
//  Description : Combinational round-robin search for the first request at or
//                after ptr, wrapping at NUM_SLAVES.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_picker #(
    parameter int NUM_SLAVES = 3,
    localparam int PTR_W     = $clog2(NUM_SLAVES)
) (
    input  logic [NUM_SLAVES-1:0] req,
    input  logic [PTR_W-1:0]      ptr,
    output logic [PTR_W-1:0]      idx,
    output logic                  found
);

    always_comb begin
        int c;
        found = 1'b0;
        idx   = '0;
        c     = 0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            c = int'(ptr) + i;
            if (c >= NUM_SLAVES) begin
                c = c - NUM_SLAVES;
            end
            if (!found && req[c]) begin
                found = 1'b1;
                idx   = PTR_W'(c);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi_r_router.sv
`default_nettype none
// ============================================================================
//  Module      : axi_r_router
//  Description : Routes slave R bursts back to M0/M1 by the IDS master tag,
//                round-robin among slaves, grant held until RLAST.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_r_router
    import axi_r_pkg::*;
#(
    parameter int NUM_SLAVES = 3,
    parameter int ID_BITS    = 4,
    parameter int IDS_BITS   = 8,
    parameter int DATA_BITS  = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SLAVES*IDS_BITS-1:0]  RID_S,
    input  logic [NUM_SLAVES*DATA_BITS-1:0] RDATA_S,
    input  logic [NUM_SLAVES*2-1:0]         RRESP_S,
    input  logic [NUM_SLAVES-1:0]           RLAST_S,
    input  logic [NUM_SLAVES-1:0]           RVALID_S,
    output logic [NUM_SLAVES-1:0]           RREADY_S,
    output logic [ID_BITS-1:0]            RID_M0,
    output logic [DATA_BITS-1:0]          RDATA_M0,
    output logic [1:0]                    RRESP_M0,
    output logic                          RLAST_M0,
    output logic                          RVALID_M0,
    input  logic                          RREADY_M0,
    output logic [ID_BITS-1:0]            RID_M1,
    output logic [DATA_BITS-1:0]          RDATA_M1,
    output logic [1:0]                    RRESP_M1,
    output logic                          RLAST_M1,
    output logic                          RVALID_M1,
    input  logic                          RREADY_M1,
    output logic                          busy,
    output logic                          decerr
);

    localparam int PTR_W = $clog2(NUM_SLAVES);
    localparam logic [PTR_W-1:0] c_last_idx = PTR_W'(NUM_SLAVES - 1);

    r_state_t         r_state;
    logic [PTR_W-1:0] r_rr_ptr;
    logic [PTR_W-1:0] r_lock_sel;
    logic             r_busy;
    logic             r_decerr;

    logic [PTR_W-1:0]      w_pick;
    logic                  w_found;
    logic [PTR_W-1:0]      w_cand;
    logic                  w_cand_valid;
    logic                  w_sel_valid;
    r_beat_t               w_beat;
    logic [3:0]            w_tag;
    logic                  w_to_m0;
    logic                  w_to_m1;
    logic                  w_bad;
    logic                  w_route_ready;
    logic                  w_hs;
    logic [PTR_W-1:0]      w_next_ptr;
    logic [NUM_SLAVES-1:0] w_rready_s;

    rr_picker #(
        .NUM_SLAVES (NUM_SLAVES)
    ) u_picker (
        .req   (RVALID_S),
        .ptr   (r_rr_ptr),
        .idx   (w_pick),
        .found (w_found)
    );

    // A locked burst ignores every other slave, even when its own valid drops.
    assign w_cand = (r_state == ST_BURST) ? r_lock_sel : w_pick;

    always_comb begin
        w_beat      = '0;
        w_sel_valid = 1'b0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (w_cand == PTR_W'(k)) begin
                w_beat.ids  = RID_S[k*IDS_BITS +: IDS_BITS];
                w_beat.data = RDATA_S[k*DATA_BITS +: DATA_BITS];
                w_beat.resp = RRESP_S[k*2 +: 2];
                w_beat.last = RLAST_S[k];
                w_sel_valid = RVALID_S[k];
            end
        end
    end

    assign w_cand_valid = (r_state == ST_BURST) ? w_sel_valid : w_found;
    assign w_tag        = tag_of(w_beat.ids);
    assign w_to_m0      = w_cand_valid && (w_tag == MTAG_M0);
    assign w_to_m1      = w_cand_valid && (w_tag == MTAG_M1);
    assign w_bad        = w_cand_valid && !w_to_m0 && !w_to_m1;

    // Unroutable beats are sunk so a stray ID cannot wedge the return path.
    assign w_route_ready = w_to_m0 ? RREADY_M0 : (w_to_m1 ? RREADY_M1 : 1'b1);
    assign w_hs          = w_cand_valid && w_route_ready;
    assign w_next_ptr    = (w_cand == c_last_idx) ? '0 : w_cand + 1'b1;

    always_comb begin
        w_rready_s = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (w_cand == PTR_W'(k)) begin
                w_rready_s[k] = w_cand_valid && w_route_ready;
            end
        end
    end

    assign RREADY_S  = w_rready_s;

    assign RVALID_M0 = w_to_m0;
    assign RID_M0    = w_to_m0 ? w_beat.ids[ID_BITS-1:0] : '0;
    assign RDATA_M0  = w_to_m0 ? w_beat.data : '0;
    assign RRESP_M0  = w_to_m0 ? w_beat.resp : 2'b00;
    assign RLAST_M0  = w_to_m0 && w_beat.last;

    assign RVALID_M1 = w_to_m1;
    assign RID_M1    = w_to_m1 ? w_beat.ids[ID_BITS-1:0] : '0;
    assign RDATA_M1  = w_to_m1 ? w_beat.data : '0;
    assign RRESP_M1  = w_to_m1 ? w_beat.resp : 2'b00;
    assign RLAST_M1  = w_to_m1 && w_beat.last;

    assign busy   = r_busy;
    assign decerr = r_decerr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_rr_ptr   <= '0;
            r_lock_sel <= '0;
            r_busy     <= 1'b0;
            r_decerr   <= 1'b0;
        end else begin
            r_decerr <= w_hs && w_bad;
            if (w_hs) begin
                if (w_beat.last) begin
                    r_state  <= ST_IDLE;
                    r_rr_ptr <= w_next_ptr;
                    r_busy   <= 1'b0;
                end else begin
                    r_state    <= ST_BURST;
                    r_lock_sel <= w_cand;
                    r_busy     <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_r_router.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_r_router
//  Description : Directed self-checking bench for axi_r_router (3 slaves).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_r_router;

    localparam int N = 3;

    logic clk = 1'b0;
    logic rst;

    logic [7:0]   rid   [N];
    logic [31:0]  rdata [N];
    logic [1:0]   rresp [N];
    logic [N-1:0] rlast;
    logic [N-1:0] rvalid;

    logic [N*8-1:0]  RID_S;
    logic [N*32-1:0] RDATA_S;
    logic [N*2-1:0]  RRESP_S;
    logic [N-1:0]    RREADY_S;
    logic [3:0]  RID_M0, RID_M1;
    logic [31:0] RDATA_M0, RDATA_M1;
    logic [1:0]  RRESP_M0, RRESP_M1;
    logic RLAST_M0, RLAST_M1, RVALID_M0, RVALID_M1;
    logic RREADY_M0, RREADY_M1;
    logic busy, decerr;

    int checks = 0;
    int errors = 0;

    assign RID_S   = {rid[2], rid[1], rid[0]};
    assign RDATA_S = {rdata[2], rdata[1], rdata[0]};
    assign RRESP_S = {rresp[2], rresp[1], rresp[0]};

    axi_r_router #(
        .NUM_SLAVES (N),
        .ID_BITS    (4),
        .IDS_BITS   (8),
        .DATA_BITS  (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .RID_S     (RID_S),
        .RDATA_S   (RDATA_S),
        .RRESP_S   (RRESP_S),
        .RLAST_S   (rlast),
        .RVALID_S  (rvalid),
        .RREADY_S  (RREADY_S),
        .RID_M0    (RID_M0),
        .RDATA_M0  (RDATA_M0),
        .RRESP_M0  (RRESP_M0),
        .RLAST_M0  (RLAST_M0),
        .RVALID_M0 (RVALID_M0),
        .RREADY_M0 (RREADY_M0),
        .RID_M1    (RID_M1),
        .RDATA_M1  (RDATA_M1),
        .RRESP_M1  (RRESP_M1),
        .RLAST_M1  (RLAST_M1),
        .RVALID_M1 (RVALID_M1),
        .RREADY_M1 (RREADY_M1),
        .busy      (busy),
        .decerr    (decerr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_slaves();
        for (int k = 0; k < N; k++) begin
            rid[k]   = 8'h00;
            rdata[k] = 32'h0;
            rresp[k] = 2'b00;
        end
        rlast  = '0;
        rvalid = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        RREADY_M0 = 1'b1;
        RREADY_M1 = 1'b1;
        clr_slaves();
        tick();
        tick();
        #2;
        checks++; if (RVALID_M0 !== 1'b0) begin errors++; $display("FAIL reset_rvalid_m0: got %b exp 0", RVALID_M0); end
        checks++; if (RVALID_M1 !== 1'b0) begin errors++; $display("FAIL reset_rvalid_m1: got %b exp 0", RVALID_M1); end
        checks++; if (RREADY_S !== 3'b000) begin errors++; $display("FAIL reset_rready_s: got %b exp 000", RREADY_S); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
        checks++; if (decerr !== 1'b0) begin errors++; $display("FAIL reset_decerr: got %b exp 0", decerr); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_beat();
        rid[1] = 8'h23; rdata[1] = 32'hDEADBEEF; rlast[1] = 1'b1; rvalid[1] = 1'b1;
        #2;
        checks++; if (RVALID_M1 !== 1'b1) begin errors++; $display("FAIL single_rvalid_m1: got %b exp 1", RVALID_M1); end
        checks++; if (RID_M1 !== 4'h3) begin errors++; $display("FAIL single_rid_m1: got %h exp 3", RID_M1); end
        checks++; if (RDATA_M1 !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rdata_m1: got %h exp deadbeef", RDATA_M1); end
        checks++; if (RLAST_M1 !== 1'b1) begin errors++; $display("FAIL single_rlast_m1: got %b exp 1", RLAST_M1); end
        checks++; if (RREADY_S !== 3'b010) begin errors++; $display("FAIL single_rready_s: got %b exp 010", RREADY_S); end
        checks++; if (RVALID_M0 !== 1'b0 || RDATA_M0 !== 32'h0) begin errors++; $display("FAIL single_m0_idle: got v=%b d=%h exp v=0 d=0", RVALID_M0, RDATA_M0); end
        tick();
        // Pointer should now sit at S2: S0 and S2 contend, S2 must win.
        clr_slaves();
        rid[0] = 8'h10; rdata[0] = 32'h1; rlast[0] = 1'b1; rvalid[0] = 1'b1;
        rid[2] = 8'h10; rdata[2] = 32'h2; rlast[2] = 1'b1; rvalid[2] = 1'b1;
        #2;
        checks++; if (RREADY_S !== 3'b100) begin errors++; $display("FAIL single_ptr_rready_s: got %b exp 100", RREADY_S); end
        checks++; if (RDATA_M0 !== 32'h2) begin errors++; $display("FAIL single_ptr_rdata_m0: got %h exp 2", RDATA_M0); end
        tick();
        clr_slaves();
    endtask

    task automatic test_burst_hold();
        for (int b = 1; b <= 4; b++) begin
            rid[0] = 8'h15; rdata[0] = 32'hA000_0000 + b; rlast[0] = (b == 4); rvalid[0] = 1'b1;
            if (b >= 2) begin
                rid[2] = 8'h2A; rdata[2] = 32'h0000_C0DE; rlast[2] = 1'b1; rvalid[2] = 1'b1;
            end
            #2;
            checks++; if (RREADY_S !== 3'b001) begin errors++; $display("FAIL burst_rready_s beat %0d: got %b exp 001", b, RREADY_S); end
            checks++; if (RDATA_M0 !== 32'hA000_0000 + b || RID_M0 !== 4'h5) begin errors++; $display("FAIL burst_data beat %0d: got d=%h id=%h exp d=%h id=5", b, RDATA_M0, RID_M0, 32'hA000_0000 + b); end
            checks++; if (RLAST_M0 !== (b == 4)) begin errors++; $display("FAIL burst_rlast beat %0d: got %b exp %b", b, RLAST_M0, (b == 4)); end
            checks++; if (busy !== (b >= 2)) begin errors++; $display("FAIL burst_busy beat %0d: got %b exp %b", b, busy, (b >= 2)); end
            checks++; if (RVALID_M1 !== 1'b0) begin errors++; $display("FAIL burst_m1_quiet beat %0d: got %b exp 0", b, RVALID_M1); end
            tick();
        end
        rvalid[0] = 1'b0; rlast[0] = 1'b0;
        #2;
        checks++; if (RREADY_S !== 3'b100) begin errors++; $display("FAIL burst_s2_rready: got %b exp 100", RREADY_S); end
        checks++; if (RVALID_M1 !== 1'b1 || RID_M1 !== 4'hA || RDATA_M1 !== 32'h0000_C0DE) begin errors++; $display("FAIL burst_s2_route: got v=%b id=%h d=%h exp v=1 id=a d=0000c0de", RVALID_M1, RID_M1, RDATA_M1); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL burst_idle_busy: got %b exp 0", busy); end
        tick();
        clr_slaves();
    endtask

    task automatic test_backpressure();
        int beat_sched  [7] = '{1, 2, 2, 2, 2, 3, 4};
        logic rdy_sched [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        int rx = 0;
        for (int c = 0; c < 7; c++) begin
            rid[0] = 8'h15; rdata[0] = 32'hB000_0000 + beat_sched[c];
            rlast[0] = (beat_sched[c] == 4); rvalid[0] = 1'b1;
            RREADY_M0 = rdy_sched[c];
            #2;
            checks++; if (RREADY_S !== (rdy_sched[c] ? 3'b001 : 3'b000)) begin errors++; $display("FAIL bp_rready_s cycle %0d: got %b exp %b", c, RREADY_S, (rdy_sched[c] ? 3'b001 : 3'b000)); end
            checks++; if (RVALID_M0 !== 1'b1 || RDATA_M0 !== 32'hB000_0000 + beat_sched[c]) begin errors++; $display("FAIL bp_data cycle %0d: got v=%b d=%h exp v=1 d=%h", c, RVALID_M0, RDATA_M0, 32'hB000_0000 + beat_sched[c]); end
            checks++; if (busy !== (c >= 1)) begin errors++; $display("FAIL bp_busy cycle %0d: got %b exp %b", c, busy, (c >= 1)); end
            if (RVALID_M0 && RREADY_M0) rx++;
            tick();
        end
        checks++; if (rx != 4) begin errors++; $display("FAIL bp_beat_count: got %0d exp 4", rx); end
        RREADY_M0 = 1'b1;
        clr_slaves();
    endtask

    task automatic test_round_robin();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < N; k++) begin
            rid[k] = 8'h10 + 8'(k); rdata[k] = 32'(k); rlast[k] = 1'b1; rvalid[k] = 1'b1;
        end
        for (int c = 0; c < 4; c++) begin
            #2;
            checks++; if (RREADY_S !== 3'(1 << (c % 3))) begin errors++; $display("FAIL rr_grant cycle %0d: got %b exp %b", c, RREADY_S, 3'(1 << (c % 3))); end
            checks++; if (RID_M0 !== 4'(c % 3)) begin errors++; $display("FAIL rr_rid cycle %0d: got %h exp %h", c, RID_M0, 4'(c % 3)); end
            tick();
        end
        clr_slaves();
    endtask

    task automatic test_bad_tag();
        rid[2] = 8'h47; rdata[2] = 32'h5; rlast[2] = 1'b1; rvalid[2] = 1'b1;
        #2;
        checks++; if (RREADY_S !== 3'b100) begin errors++; $display("FAIL bad_rready_s: got %b exp 100", RREADY_S); end
        checks++; if (RVALID_M0 !== 1'b0 || RVALID_M1 !== 1'b0) begin errors++; $display("FAIL bad_no_master: got m0=%b m1=%b exp 0 0", RVALID_M0, RVALID_M1); end
        checks++; if (decerr !== 1'b0) begin errors++; $display("FAIL bad_decerr_early: got %b exp 0", decerr); end
        tick();
        clr_slaves();
        #2;
        checks++; if (decerr !== 1'b1) begin errors++; $display("FAIL bad_decerr_pulse: got %b exp 1", decerr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bad_busy: got %b exp 0", busy); end
        tick();
        rid[0] = 8'h10; rdata[0] = 32'h9; rlast[0] = 1'b1; rvalid[0] = 1'b1;
        #2;
        checks++; if (decerr !== 1'b0) begin errors++; $display("FAIL bad_decerr_clear: got %b exp 0", decerr); end
        checks++; if (RREADY_S !== 3'b001 || RVALID_M0 !== 1'b1) begin errors++; $display("FAIL bad_back_idle: got r=%b v=%b exp r=001 v=1", RREADY_S, RVALID_M0); end
        tick();
        clr_slaves();
    endtask

    task automatic test_reset_mid_burst();
        // Pointer is at S1 here; start an 8-beat S1 burst to M1.
        rid[1] = 8'h2B; rdata[1] = 32'h1; rlast[1] = 1'b0; rvalid[1] = 1'b1;
        #2;
        checks++; if (RREADY_S !== 3'b010 || RVALID_M1 !== 1'b1) begin errors++; $display("FAIL rstb_beat1: got r=%b v=%b exp r=010 v=1", RREADY_S, RVALID_M1); end
        tick();
        rdata[1] = 32'h2;
        rst = 1'b1;
        #2;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstb_locked: got %b exp 1", busy); end
        tick();
        rst = 1'b0;
        rdata[1] = 32'h3;
        rid[0] = 8'h15; rdata[0] = 32'h77; rlast[0] = 1'b0; rvalid[0] = 1'b1;
        #2;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstb_busy_dropped: got %b exp 0", busy); end
        checks++; if (RREADY_S !== 3'b001 || RVALID_M0 !== 1'b1 || RVALID_M1 !== 1'b0) begin errors++; $display("FAIL rstb_s0_grant: got r=%b m0=%b m1=%b exp r=001 m0=1 m1=0", RREADY_S, RVALID_M0, RVALID_M1); end
        tick();
        #2;
        checks++; if (busy !== 1'b1 || RREADY_S !== 3'b001) begin errors++; $display("FAIL rstb_s0_locked: got busy=%b r=%b exp busy=1 r=001", busy, RREADY_S); end
        clr_slaves();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_burst_hold();
        test_backpressure();
        test_round_robin();
        test_bad_tag();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
